// File: rtl/fwrisc_uart_pkg.sv
// Shared types and default timing constants for the fwrisc UART program loader.
package fwrisc_uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    LD_WAIT,
    LD_RECV,
    LD_DONE
  } ld_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT   = 434;        // 50 MHz / 115200
  localparam int unsigned DEFAULT_MEM_WORDS      = 4096;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 5_000_000;

endpackage

// File: rtl/fwrisc_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, one-cycle byte strobe.
module fwrisc_uart_rx
  import fwrisc_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_e     r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          w_rx;

  assign w_rx         = r_sync[1];
  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_data;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_valid <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_state <= RX_START;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            // A low stop bit is a framing error; the byte is simply not presented.
            if (w_rx) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fwrisc_uart_loader.sv
// Packs received UART bytes little-endian into instruction-RAM words; ends the load on idle timeout.
module fwrisc_uart_loader
  import fwrisc_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned MEM_WORDS      = DEFAULT_MEM_WORDS,
  parameter int unsigned ADDR_WIDTH     = $clog2(MEM_WORDS),
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  program_receiving,
  output logic                  program_ov,
  output logic                  program_done,
  output logic                  core_reset_n
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH:0] WORD_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

  ld_state_e             r_state;
  logic [1:0]            r_lane;
  logic [31:0]           r_buf;
  logic [ADDR_WIDTH:0]   r_word_idx;
  logic [TW-1:0]         r_idle;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_ov;

  logic                  w_byte_valid;
  logic [7:0]            w_byte_data;
  logic [31:0]           w_word;
  logic                  w_timeout;
  logic                  w_emit;
  logic [31:0]           w_emit_data;

  fwrisc_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_rx        (rx),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data)
  );

  // Lane 0 restarts the buffer so a timed-out partial word carries zero upper bytes.
  always_comb begin
    w_word = r_buf;
    case (r_lane)
      2'd0: w_word = {24'h0, w_byte_data};
      2'd1: w_word[15:8]  = w_byte_data;
      2'd2: w_word[23:16] = w_byte_data;
      2'd3: w_word[31:24] = w_byte_data;
      default: w_word = r_buf;
    endcase
  end

  assign w_timeout   = !w_byte_valid && (r_idle == TIMEOUT_MAX);
  assign w_emit      = (r_state == LD_RECV) &&
                       ((w_byte_valid && r_lane == 2'd3) || (w_timeout && r_lane != 2'd0));
  assign w_emit_data = w_byte_valid ? w_word : r_buf;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= LD_WAIT;
      r_lane      <= '0;
      r_buf       <= '0;
      r_word_idx  <= '0;
      r_idle      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ov        <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        LD_WAIT: begin
          if (w_byte_valid) begin
            r_state <= LD_RECV;
            r_buf   <= w_word;
            r_lane  <= r_lane + 2'd1;
            r_idle  <= '0;
          end
        end
        LD_RECV: begin
          if (w_byte_valid) begin
            r_buf  <= w_word;
            r_lane <= r_lane + 2'd1;
            r_idle <= '0;
          end else if (!w_timeout) begin
            r_idle <= r_idle + 1'b1;
          end else begin
            r_state <= LD_DONE;
          end
          if (w_emit) begin
            if (r_word_idx < WORD_LIMIT) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
              r_mem_wdata <= w_emit_data;
              r_word_idx  <= r_word_idx + 1'b1;
            end else begin
              r_ov <= 1'b1;
            end
          end
        end
        default: r_state <= LD_DONE;
      endcase
    end
  end

  assign mem_we            = r_mem_we;
  assign mem_addr          = r_mem_addr;
  assign mem_wdata         = r_mem_wdata;
  assign program_ov        = r_ov;
  assign program_receiving = (r_state == LD_RECV);
  assign program_done      = (r_state == LD_DONE);
  assign core_reset_n      = program_done;

endmodule

// File: tb/tb_fwrisc_uart_loader.sv
// Directed bench for fwrisc_uart_loader with shortened baud, RAM depth and timeout.
module tb_fwrisc_uart_loader;

  localparam int unsigned CPB = 8;
  localparam int unsigned MW  = 4;
  localparam int unsigned AW  = 2;
  localparam int unsigned TO  = 200;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx    = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          program_receiving;
  logic          program_ov;
  logic          program_done;
  logic          core_reset_n;

  int checks   = 0;
  int failures = 0;

  int          wr_total = 0;
  int          bv_total = 0;
  logic [31:0] wr_data [0:63];
  logic [31:0] wr_addr [0:63];
  logic        wr_done [0:63];

  always #5 clock = ~clock;

  fwrisc_uart_loader #(
    .CLKS_PER_BIT  (CPB),
    .MEM_WORDS     (MW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .rx               (rx),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .program_receiving(program_receiving),
    .program_ov       (program_ov),
    .program_done     (program_done),
    .core_reset_n     (core_reset_n)
  );

  // Write / byte-strobe recorder, sampled on the falling edge.
  always @(negedge clock) begin
    if (mem_we === 1'b1 && wr_total < 64) begin
      wr_data[wr_total] = mem_wdata;
      wr_addr[wr_total] = 32'(mem_addr);
      wr_done[wr_total] = program_done;
      wr_total = wr_total + 1;
    end
    if (dut.w_byte_valid === 1'b1) bv_total = bv_total + 1;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},   32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_recv"}, 32'(program_receiving), 32'd0);
    check({tag, "_ov"},   32'(program_ov), 32'd0);
    check({tag, "_done"}, 32'(program_done), 32'd0);
    check({tag, "_crst"}, 32'(core_reset_n), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    repeat (2) tick();
    check_zero(tag);
    reset = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) tick();
    end
    rx = stop_bit;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (program_done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(program_done), 32'd1);
  endtask

  initial begin
    int b;
    int bv0;

    // Reset state
    tick();
    do_reset("reset");

    // Glitch shorter than half a bit
    b = wr_total;
    bv0 = bv_total;
    rx = 1'b0;
    repeat (CPB / 4) tick();
    rx = 1'b1;
    repeat (4 * CPB) tick();
    check("glitch_bv", 32'(bv_total - bv0), 32'd0);
    check("glitch_recv", 32'(program_receiving), 32'd0);
    check("glitch_we", 32'(wr_total - b), 32'd0);

    // Single word
    b = wr_total;
    send_byte(8'h13, 1'b1);
    check("single_recv_rise", 32'(program_receiving), 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("single_count", 32'(wr_total - b), 32'd1);
    check("single_addr", wr_addr[b], 32'd0);
    check("single_data", wr_data[b], 32'h0000_0013);
    check("single_done_at_wr", 32'(wr_done[b]), 32'd0);
    check("single_not_done", 32'(program_done), 32'd0);
    wait_done("single");
    check("single_count_after", 32'(wr_total - b), 32'd1);
    check("single_crst", 32'(core_reset_n), 32'd1);
    check("single_recv_low", 32'(program_receiving), 32'd0);

    // Partial word flushed on timeout
    do_reset("reset2");
    b = wr_total;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("partial_count_pre", 32'(wr_total - b), 32'd1);
    wait_done("partial");
    check("partial_count", 32'(wr_total - b), 32'd2);
    check("partial_addr0", wr_addr[b], 32'd0);
    check("partial_data0", wr_data[b], 32'h0403_0201);
    check("partial_addr1", wr_addr[b+1], 32'd1);
    check("partial_data1", wr_data[b+1], 32'h0000_BBAA);
    check("partial_flush_with_done", 32'(wr_done[b+1]), 32'd1);
    check("partial_crst", 32'(core_reset_n), 32'd1);
    check("partial_recv", 32'(program_receiving), 32'd0);
    check("partial_ov", 32'(program_ov), 32'd0);

    // Overflow with a 4-word RAM
    do_reset("reset3");
    b = wr_total;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    check("ov_count4", 32'(wr_total - b), 32'd4);
    check("ov_not_yet", 32'(program_ov), 32'd0);
    for (int i = 16; i < 20; i++) send_byte(8'(i), 1'b1);
    check("ov_set", 32'(program_ov), 32'd1);
    check("ov_count_hold", 32'(wr_total - b), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("ov_addr", wr_addr[b+k], 32'(k));
      check("ov_data", wr_data[b+k],
            {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    wait_done("ov");
    check("ov_count_final", 32'(wr_total - b), 32'd4);
    check("ov_sticky", 32'(program_ov), 32'd1);

    // Framing error then a good word
    do_reset("reset4");
    b = wr_total;
    bv0 = bv_total;
    send_byte(8'h55, 1'b0);
    check("frame_bv", 32'(bv_total - bv0), 32'd0);
    check("frame_recv", 32'(program_receiving), 32'd0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("frame_count", 32'(wr_total - b), 32'd1);
    check("frame_addr", wr_addr[b], 32'd0);
    check("frame_data", wr_data[b], 32'h4433_2211);

    // Reset in the middle of a word
    do_reset("reset5");
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    check("mid_recv", 32'(program_receiving), 32'd1);
    reset = 1'b0;
    tick();
    check_zero("mid_rst");
    reset = 1'b1;
    tick();
    b = wr_total;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    check("mid_count", 32'(wr_total - b), 32'd1);
    check("mid_addr", wr_addr[b], 32'd0);
    check("mid_data", wr_data[b], 32'h0403_0201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
